// File: rtl/babbage_pkg.sv
// Shared definitions for the finite-difference polynomial engine.
//   state_e      : controller states (IDLE, SEED, DIFF, RUN)
//   seed_cnt_w() : width of the Horner point/coefficient indices (0..DEG)
//   pass_cnt_w() : width of the difference-pass counter (1..DEG)
package babbage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    DIFF = 2'd2,
    RUN  = 2'd3
  } state_e;

  // Bits needed to index n distinct values, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int seed_cnt_w(input int deg);
    return cnt_w(deg + 1);
  endfunction

  function automatic int pass_cnt_w(input int deg);
    return cnt_w(deg + 1);
  endfunction

endpackage

// File: rtl/babbage_horner.sv
// Sequential Horner evaluator producing p(j) for j = 0, 1, 2, ...
// One multiply-add per step; DEG steps per point.
//   clk, rst : clock, synchronous active-high reset
//   load     : latch coef, restart at j = 0 with acc = a_DEG
//   step     : perform one multiply-add acc*j + a_i
//   coef     : a_i at bits [i*CW +: CW] (sampled on load only)
//   j        : point currently being evaluated
//   acc      : result of this cycle's multiply-add
//   done     : step completes p(j); acc then holds p(j)
module babbage_horner
  import babbage_pkg::*;
#(
  parameter int DEG = 3,
  parameter int CW  = 8,
  parameter int YW  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step,
  input  logic [(DEG+1)*CW-1:0]        coef,
  output logic [seed_cnt_w(DEG)-1:0]   j,
  output logic [YW-1:0]                acc,
  output logic                         done
);

  localparam int JW = seed_cnt_w(DEG);

  logic [(DEG+1)*CW-1:0] coef_q;
  logic [CW-1:0]         a [0:DEG];
  logic [YW-1:0]         acc_q;
  logic [JW-1:0]         i_q;
  logic [JW-1:0]         j_q;

  always_comb begin
    for (int k = 0; k <= DEG; k++) a[k] = coef_q[k*CW +: CW];
  end

  always_comb begin
    acc  = acc_q * YW'(j_q);
    acc  = acc + YW'(a[i_q]);
    done = step && (i_q == '0);
    j    = j_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q <= '0;
      acc_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else if (load) begin
      coef_q <= coef;
      acc_q  <= YW'(coef[DEG*CW +: CW]);
      i_q    <= JW'(DEG - 1);
      j_q    <= '0;
    end else if (step) begin
      if (i_q == '0) begin
        // Point finished: restart the chain for the next j.
        acc_q <= YW'(a[DEG]);
        i_q   <= JW'(DEG - 1);
        j_q   <= j_q + JW'(1);
      end else begin
        acc_q <= acc;
        i_q   <= i_q - JW'(1);
      end
    end
  end

endmodule

// File: rtl/babbage_poly.sv
// Finite-difference polynomial engine: p(n) = sum a_i*n^i for n = 0..x.
// Seeds d[0..DEG] with p(0..DEG) by Horner, converts them to forward
// differences, then produces one value per cycle with additions only.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted when ready
//   mode     : 0 = only p(x); 1 = stream p(0..x)
//   x        : final argument (latched on accept)
//   coef     : a_i at bits [i*CW +: CW] (latched on accept)
//   ready    : engine idle
//   valid    : y holds a result
//   last     : with valid, y is p(x)
//   y        : result, 0 when not valid
module babbage_poly
  import babbage_pkg::*;
#(
  parameter int DEG = 3,
  parameter int CW  = 8,
  parameter int XW  = 8,
  parameter int YW  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [XW-1:0]         x,
  input  logic [(DEG+1)*CW-1:0] coef,
  output logic                  ready,
  output logic                  valid,
  output logic                  last,
  output logic [YW-1:0]         y
);

  localparam int JW = seed_cnt_w(DEG);
  localparam int PW = pass_cnt_w(DEG);

  state_e          state, state_nxt;
  logic [YW-1:0]   d [0:DEG];
  logic [XW-1:0]   n;
  logic [XW-1:0]   x_q;
  logic            mode_q;
  logic [PW-1:0]   m;

  logic            accept;
  logic            h_step;
  logic [JW-1:0]   h_j;
  logic [YW-1:0]   h_acc;
  logic            h_done;
  logic            at_end;

  assign accept = (state == IDLE) && start;
  assign h_step = (state == SEED);
  assign at_end = (n == x_q);

  babbage_horner #(
    .DEG (DEG),
    .CW  (CW),
    .YW  (YW)
  ) u_horner (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .step (h_step),
    .coef (coef),
    .j    (h_j),
    .acc  (h_acc),
    .done (h_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;
    y         = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = SEED;
      end
      SEED: begin
        if (h_done && (h_j == JW'(DEG))) state_nxt = DIFF;
      end
      DIFF: begin
        if (m == PW'(DEG)) state_nxt = RUN;
      end
      RUN: begin
        valid = mode_q || at_end;
        last  = at_end;
        if (valid) y = d[0];
        if (at_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n      <= '0;
      x_q    <= '0;
      mode_q <= 1'b0;
      m      <= '0;
      for (int k = 0; k <= DEG; k++) d[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q    <= x;
            mode_q <= mode;
            n      <= '0;
            m      <= PW'(1);
          end
        end
        // Seed stage: d[j] <= p(j) as each Horner point completes.
        SEED: begin
          if (h_done) d[h_j] <= h_acc;
        end
        // Difference stage: pass m leaves d[0..m-1] final.
        DIFF: begin
          for (int k = 1; k <= DEG; k++) begin
            if (k >= int'(m)) d[k] <= d[k] - d[k-1];
          end
          m <= m + PW'(1);
        end
        // Run stage: d[0] is p(n); advance every difference by one step.
        RUN: begin
          for (int k = 0; k < DEG; k++) d[k] <= d[k] + d[k+1];
          n <= n + XW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_babbage_poly.sv
// Bench for babbage_poly: three instances (DEG=3/YW=32, DEG=3/YW=8,
// DEG=1/YW=32). Stimulus pushes hand-computed results with their cycle
// into per-instance queues; monitors pop and compare on every valid.
module tb_babbage_poly;

  typedef struct {
    int     cyc;
    longint y;
    bit     last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DEG=3, YW=32
  logic        a_start = 0, a_mode = 0;
  logic [7:0]  a_x = 0;
  logic [31:0] a_coef = 0;
  logic        a_ready, a_valid, a_last;
  logic [31:0] a_y;
  // Instance B: DEG=3, YW=8
  logic        b_start = 0, b_mode = 0;
  logic [7:0]  b_x = 0;
  logic [31:0] b_coef = 0;
  logic        b_ready, b_valid, b_last;
  logic [7:0]  b_y;
  // Instance C: DEG=1, YW=32
  logic        c_start = 0, c_mode = 0;
  logic [7:0]  c_x = 0;
  logic [15:0] c_coef = 0;
  logic        c_ready, c_valid, c_last;
  logic [31:0] c_y;

  exp_t qa[$], qb[$], qc[$];

  babbage_poly #(.DEG(3), .CW(8), .XW(8), .YW(32)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .x(a_x), .coef(a_coef),
    .ready(a_ready), .valid(a_valid), .last(a_last), .y(a_y));
  babbage_poly #(.DEG(3), .CW(8), .XW(8), .YW(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .x(b_x), .coef(b_coef),
    .ready(b_ready), .valid(b_valid), .last(b_last), .y(b_y));
  babbage_poly #(.DEG(1), .CW(8), .XW(8), .YW(32)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .x(c_x), .coef(c_coef),
    .ready(c_ready), .valid(c_valid), .last(c_last), .y(c_y));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_one(input string tag, input bit v, input bit l, input longint yv,
                             inout exp_t q[$]);
    exp_t e;
    if (v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_valid: got y=%0d expected no output (cycle %0d)", tag, yv, cyc);
      end else begin
        e = q.pop_front();
        chk({tag, "_cycle"}, cyc, e.cyc);
        chk({tag, "_y"}, yv, e.y);
        chk({tag, "_last"}, l, e.last);
      end
    end else begin
      chk({tag, "_idle_y"}, yv, 0);
      chk({tag, "_idle_last"}, l, 0);
    end
  endtask

  always @(negedge clk) monitor_one("a", a_valid, a_last, a_y, qa);
  always @(negedge clk) monitor_one("b", b_valid, b_last, b_y, qb);
  always @(negedge clk) monitor_one("c", c_valid, c_last, c_y, qc);

  task automatic push_a(input int c, input longint yv, input bit l);
    exp_t e; e.cyc = c; e.y = yv; e.last = l; qa.push_back(e);
  endtask
  task automatic push_b(input int c, input longint yv, input bit l);
    exp_t e; e.cyc = c; e.y = yv; e.last = l; qb.push_back(e);
  endtask
  task automatic push_c(input int c, input longint yv, input bit l);
    exp_t e; e.cyc = c; e.y = yv; e.last = l; qc.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Issue a job; base is the acceptance cycle (relative cycle 0).
  // Inputs are scrambled right after accept to show they are latched.
  task automatic go_a(input bit md, input int xv, input logic [31:0] cf, output int base);
    @(negedge clk);
    chk("a_ready_before_start", a_ready, 1);
    a_start = 1; a_mode = md; a_x = xv[7:0]; a_coef = cf; base = cyc;
    @(negedge clk);
    a_start = 0; a_mode = ~md; a_x = 8'hC3; a_coef = ~cf;
  endtask
  task automatic go_b(input bit md, input int xv, input logic [31:0] cf, output int base);
    @(negedge clk);
    chk("b_ready_before_start", b_ready, 1);
    b_start = 1; b_mode = md; b_x = xv[7:0]; b_coef = cf; base = cyc;
    @(negedge clk);
    b_start = 0; b_mode = ~md; b_x = 8'h5A; b_coef = ~cf;
  endtask
  task automatic go_c(input bit md, input int xv, input logic [15:0] cf, output int base);
    @(negedge clk);
    chk("c_ready_before_start", c_ready, 1);
    c_start = 1; c_mode = md; c_x = xv[7:0]; c_coef = cf; base = cyc;
    @(negedge clk);
    c_start = 0; c_mode = ~md; c_x = 8'h77; c_coef = ~cf;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pending_expected_outputs", qa.size() + qb.size() + qc.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_a_ready", a_ready, 1);
    chk("reset_a_valid", a_valid, 0);
    chk("reset_b_ready", b_ready, 1);
    chk("reset_c_ready", c_ready, 1);
    chk("reset_c_valid", c_valid, 0);

    // p(n) = n^3 + 2n^2 + 3n + 4, single result at x=5
    go_a(0, 5, 32'h01020304, b);
    push_a(b + 21, 194, 1);
    wait_cyc(b + 21);
    chk("a_ready_during_run", a_ready, 0);
    wait_cyc(b + 22);
    chk("a_ready_after_last", a_ready, 1);

    // stream p(0..3), then back-to-back x=0 jobs
    go_a(1, 3, 32'h01020304, b);
    push_a(b + 16, 4, 0);
    push_a(b + 17, 10, 0);
    push_a(b + 18, 26, 0);
    push_a(b + 19, 58, 1);
    wait_cyc(b + 19);
    chk("a_ready_on_last", a_ready, 0);
    go_a(0, 0, 32'h01020304, b);
    push_a(b + 16, 4, 1);
    wait_cyc(b + 16);
    go_a(1, 0, 32'h01020304, b);
    push_a(b + 16, 4, 1);
    wait_cyc(b + 17);
    chk("a_ready_after_x0", a_ready, 1);

    // full-scale coefficients: 255*(8+4+2+1) at x=2
    go_a(0, 2, 32'hFFFFFFFF, b);
    push_a(b + 18, 3825, 1);
    drain(40);

    // 8-bit datapath wrap: 7^3 = 343 -> 87
    go_b(0, 7, 32'h01000000, b);
    push_b(b + 23, 87, 1);
    drain(40);

    // degree 1: 3n + 5, start pulse during SEED must be ignored
    go_c(0, 4, 16'h0305, b);
    push_c(b + 8, 17, 1);
    chk("c_ready_in_seed", c_ready, 0);
    c_start = 1; c_mode = 1; c_x = 8'd1;
    @(negedge clk);
    c_start = 0;
    drain(40);
    go_c(1, 4, 16'h0305, b);
    push_c(b + 4, 5, 0);
    push_c(b + 5, 8, 0);
    push_c(b + 6, 11, 0);
    push_c(b + 7, 14, 0);
    push_c(b + 8, 17, 1);
    drain(40);

    // abort mid-RUN with reset; simultaneous start must lose
    go_a(1, 10, 32'h01020304, b);
    push_a(b + 16, 4, 0);
    push_a(b + 17, 10, 0);
    push_a(b + 18, 26, 0);
    wait_cyc(b + 18);
    rst = 1; a_start = 1; a_mode = 0; a_x = 8'd5; a_coef = 32'h01020304;
    @(negedge clk);
    chk("a_ready_after_abort", a_ready, 1);
    chk("a_valid_after_abort", a_valid, 0);
    chk("a_y_after_abort", a_y, 0);
    rst = 0; a_start = 0;
    @(negedge clk);
    chk("a_ready_rst_beats_start", a_ready, 1);
    go_a(0, 5, 32'h01020304, b);
    push_a(b + 21, 194, 1);
    drain(40);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
